vpg_timing_gen: RTL and testbench

- Parametrised successor to the fixed 640x480 video pattern generator.
- Generates HS/VS/DE timing from per-instance parameters, with configurable sync polarity and a pixel-enable input.
- Outputs aligned active-pixel coordinates and frame/line strobes.
- Produces one of four test patterns, selected at run time and switched only at frame boundaries.
- Sits between the pixel-clock domain and the HDMI/VGA transmitter; also serves as the timing master for later framebuffer readout.

---
 rtl/vpg_pkg.sv | 28 ++
 rtl/vpg_pattern.sv | 56 +++++
 rtl/vpg_timing_gen.sv | 169 ++++++++++++++++
 tb/tb_vpg_timing_gen.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/vpg_pkg.sv
// Shared types and constants for the parametrised video timing / pattern generator.
package vpg_pkg;

  typedef enum logic [1:0] {
    PAT_BARS  = 2'd0,
    PAT_RAMP  = 2'd1,
    PAT_CHECK = 2'd2,
    PAT_SOLID = 2'd3
  } pat_e;

  // Pipeline depth from counter state to the output pins.
  localparam int VPG_LAT = 2;

  // Bar 0 (leftmost) is the lowest index: white, yellow, cyan, green, magenta, red, blue, black.
  localparam logic [7:0][23:0] BAR_RGB = {
    24'h000000, 24'h0000FF, 24'hFF0000, 24'hFF00FF,
    24'h00FF00, 24'h00FFFF, 24'hFFFF00, 24'hFFFFFF
  };

  typedef struct packed {
    logic de;
    logic hs;
    logic vs;
    logic fs;
    logic ls;
  } sync_t;

endpackage

// File: rtl/vpg_pattern.sv
// Stage-1 pattern engine: turns active-area coordinates and the latched selection into registered RGB.
module vpg_pattern
  import vpg_pkg::*;
#(
  parameter int H_ACTIVE = 640,
  parameter int CW       = 12
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          en,
  input  logic          de,
  input  logic [CW-1:0] pix_x,
  input  logic [CW-1:0] pix_y,
  input  pat_e          pat_sel,
  input  logic [23:0]   solid_rgb,
  output logic [23:0]   rgb
);

  localparam int BAR_W = H_ACTIVE / 8;

  logic [2:0]  bar_idx_s;
  logic [23:0] pat_rgb_s;
  logic        unused_pix_y_s;

  // Only bit 5 of the row matters to the checkerboard.
  assign unused_pix_y_s = ^{pix_y[CW-1:6], pix_y[4:0]};

  // Bar index counts the constant thresholds already passed, saturating naturally at 7.
  always_comb begin
    bar_idx_s = 3'd0;
    for (int i = 1; i < 8; i++) begin
      bar_idx_s = bar_idx_s + {2'b00, (pix_x >= CW'(i * BAR_W))};
    end
    case (pat_sel)
      PAT_BARS:  pat_rgb_s = BAR_RGB[bar_idx_s];
      PAT_RAMP:  pat_rgb_s = {pix_x[7:0], pix_x[7:0], pix_x[7:0]};
      PAT_CHECK: pat_rgb_s = (pix_x[5] ^ pix_y[5]) ? 24'hFFFFFF : 24'h000000;
      PAT_SOLID: pat_rgb_s = solid_rgb;
      default:   pat_rgb_s = 24'h000000;
    endcase
  end

  // Registered RGB, blanked outside the active area.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rgb <= 24'h000000;
    end else if (en) begin
      if (de) begin
        rgb <= pat_rgb_s;
      end else begin
        rgb <= 24'h000000;
      end
    end
  end

endmodule

// File: rtl/vpg_timing_gen.sv
// Parametrised video timing generator: h/v counters, sync decode, frame-latched pattern
// selection and a two-stage output pipeline keeping syncs, coordinates and RGB aligned.
module vpg_timing_gen
  import vpg_pkg::*;
#(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int CW       = 12
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          en,
  input  logic [1:0]    pattern_sel,
  input  logic [23:0]   solid_rgb,
  output logic          vpg_de,
  output logic          vpg_hs,
  output logic          vpg_vs,
  output logic [7:0]    vpg_r,
  output logic [7:0]    vpg_g,
  output logic [7:0]    vpg_b,
  output logic [CW-1:0] pix_x,
  output logic [CW-1:0] pix_y,
  output logic          frame_start,
  output logic          line_start
);

  localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;

  localparam logic [CW-1:0] H_LAST    = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST    = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_SYN_END = CW'(H_SYNC);
  localparam logic [CW-1:0] V_SYN_END = CW'(V_SYNC);
  localparam logic [CW-1:0] H_ACT_BEG = CW'(H_SYNC + H_BP);
  localparam logic [CW-1:0] V_ACT_BEG = CW'(V_SYNC + V_BP);
  localparam logic [CW-1:0] H_ACT_END = CW'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [CW-1:0] V_ACT_END = CW'(V_SYNC + V_BP + V_ACTIVE);

  localparam sync_t CTL_RST = '{de: 1'b0, hs: ~HS_POL, vs: ~VS_POL, fs: 1'b0, ls: 1'b0};

  generate
    if ((H_TOTAL >= 2**CW) || (V_TOTAL >= 2**CW)) begin : g_size_check
      $error("vpg_timing_gen: H_TOTAL or V_TOTAL does not fit in CW bits");
    end
  endgenerate

  logic [CW-1:0] h_r;
  logic [CW-1:0] v_r;
  logic          h_act_s;
  logic          v_act_s;
  sync_t         ctl_s;
  logic [CW-1:0] pix_x_s;
  logic [CW-1:0] pix_y_s;
  sync_t         ctl_r   [VPG_LAT];
  logic [CW-1:0] pix_x_r [VPG_LAT];
  logic [CW-1:0] pix_y_r [VPG_LAT];
  pat_e          pat_r;
  logic [23:0]   solid_r;
  logic [23:0]   rgb_p1_s;
  logic [23:0]   rgb_out_r;

  // Stage 0: horizontal and vertical position counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      h_r <= {CW{1'b0}};
      v_r <= {CW{1'b0}};
    end else if (en) begin
      if (h_r == H_LAST) begin
        h_r <= {CW{1'b0}};
        v_r <= (v_r == V_LAST) ? {CW{1'b0}} : v_r + {{(CW-1){1'b0}}, 1'b1};
      end else begin
        h_r <= h_r + {{(CW-1){1'b0}}, 1'b1};
      end
    end
  end

  // Stage 0 decode: sync levels, active window, coordinates and strobes.
  always_comb begin
    h_act_s  = (h_r >= H_ACT_BEG) && (h_r < H_ACT_END);
    v_act_s  = (v_r >= V_ACT_BEG) && (v_r < V_ACT_END);
    ctl_s.de = h_act_s && v_act_s;
    ctl_s.hs = (h_r < H_SYN_END) ? HS_POL : ~HS_POL;
    ctl_s.vs = (v_r < V_SYN_END) ? VS_POL : ~VS_POL;
    ctl_s.ls = (h_r == {CW{1'b0}});
    ctl_s.fs = (h_r == {CW{1'b0}}) && (v_r == {CW{1'b0}});
    if (ctl_s.de) begin
      pix_x_s = h_r - H_ACT_BEG;
      pix_y_s = v_r - V_ACT_BEG;
    end else begin
      pix_x_s = {CW{1'b0}};
      pix_y_s = {CW{1'b0}};
    end
  end

  // Control and coordinate delay line; the last entry drives the output pins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < VPG_LAT; i++) begin
        ctl_r[i]   <= CTL_RST;
        pix_x_r[i] <= {CW{1'b0}};
        pix_y_r[i] <= {CW{1'b0}};
      end
    end else if (en) begin
      ctl_r[0]   <= ctl_s;
      pix_x_r[0] <= pix_x_s;
      pix_y_r[0] <= pix_y_s;
      for (int i = 1; i < VPG_LAT; i++) begin
        ctl_r[i]   <= ctl_r[i-1];
        pix_x_r[i] <= pix_x_r[i-1];
        pix_y_r[i] <= pix_y_r[i-1];
      end
    end
  end

  // Selection is captured only at h = 0, v = 0 so a frame never mixes patterns.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pat_r   <= PAT_BARS;
      solid_r <= 24'h000000;
    end else if (en && ctl_s.fs) begin
      pat_r   <= pat_e'(pattern_sel);
      solid_r <= solid_rgb;
    end
  end

  vpg_pattern #(
    .H_ACTIVE (H_ACTIVE),
    .CW       (CW)
  ) u_pattern (
    .clk       (clk),
    .reset_n   (reset_n),
    .en        (en),
    .de        (ctl_s.de),
    .pix_x     (pix_x_s),
    .pix_y     (pix_y_s),
    .pat_sel   (pat_r),
    .solid_rgb (solid_r),
    .rgb       (rgb_p1_s)
  );

  // Stage 2 RGB output register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rgb_out_r <= 24'h000000;
    end else if (en) begin
      rgb_out_r <= rgb_p1_s;
    end
  end

  assign vpg_de      = ctl_r[VPG_LAT-1].de;
  assign vpg_hs      = ctl_r[VPG_LAT-1].hs;
  assign vpg_vs      = ctl_r[VPG_LAT-1].vs;
  assign frame_start = ctl_r[VPG_LAT-1].fs;
  assign line_start  = ctl_r[VPG_LAT-1].ls;
  assign pix_x       = pix_x_r[VPG_LAT-1];
  assign pix_y       = pix_y_r[VPG_LAT-1];
  assign vpg_r       = rgb_out_r[23:16];
  assign vpg_g       = rgb_out_r[15:8];
  assign vpg_b       = rgb_out_r[7:0];

endmodule

// File: tb/tb_vpg_timing_gen.sv
// Directed bench for vpg_timing_gen using a reduced 80x47 raster plus an active-high 48x10 instance.
module tb_vpg_timing_gen;

  localparam int HT    = 80;
  localparam int VT    = 47;
  localparam int FRAME = HT * VT;
  localparam int HAB   = 12;
  localparam int HAE   = 76;
  localparam int VAB   = 5;
  localparam int VAE   = 45;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        en = 1'b0;
  logic [1:0]  pattern_sel = 2'd0;
  logic [23:0] solid_rgb = 24'h000000;

  logic        vpg_de, vpg_hs, vpg_vs, frame_start, line_start;
  logic [7:0]  vpg_r, vpg_g, vpg_b;
  logic [11:0] pix_x, pix_y;

  logic        de2, hs2, vs2, fs2, ls2;
  logic [7:0]  r2, g2, b2;
  logic [11:0] px2, py2;

  int checks = 0;
  int passes = 0;
  int d2_de = 0, d2_hs = 0, d2_vs = 0, d2_maxx = 0;

  logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                            24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  always #5 clk = ~clk;

  vpg_timing_gen #(
    .H_ACTIVE(64), .H_FP(4), .H_SYNC(8), .H_BP(4),
    .V_ACTIVE(40), .V_FP(2), .V_SYNC(3), .V_BP(2),
    .HS_POL(1'b0), .VS_POL(1'b0), .CW(12)
  ) u_dut (
    .clk(clk), .reset_n(reset_n), .en(en), .pattern_sel(pattern_sel), .solid_rgb(solid_rgb),
    .vpg_de(vpg_de), .vpg_hs(vpg_hs), .vpg_vs(vpg_vs),
    .vpg_r(vpg_r), .vpg_g(vpg_g), .vpg_b(vpg_b),
    .pix_x(pix_x), .pix_y(pix_y), .frame_start(frame_start), .line_start(line_start)
  );

  vpg_timing_gen #(
    .H_ACTIVE(40), .H_FP(2), .H_SYNC(4), .H_BP(2),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1), .CW(12)
  ) u_dut_pos (
    .clk(clk), .reset_n(reset_n), .en(en), .pattern_sel(pattern_sel), .solid_rgb(solid_rgb),
    .vpg_de(de2), .vpg_hs(hs2), .vpg_vs(vs2),
    .vpg_r(r2), .vpg_g(g2), .vpg_b(b2),
    .pix_x(px2), .pix_y(py2), .frame_start(fs2), .line_start(ls2)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [23:0] exp_rgb(input int mode, input logic [11:0] px,
                                          input logic [11:0] py, input logic [23:0] solid);
    case (mode)
      0:       return bars[px / 12'd8];
      1:       return {px[7:0], px[7:0], px[7:0]};
      2:       return (px[5] ^ py[5]) ? 24'hFFFFFF : 24'h000000;
      default: return solid;
    endcase
  endfunction

  function automatic logic [52:0] snap();
    return {vpg_de, vpg_hs, vpg_vs, vpg_r, vpg_g, vpg_b, pix_x, pix_y, frame_start, line_start};
  endfunction

  // Entered on the sample where frame_start is high; leaves on the next frame's first sample.
  task automatic run_frame(input string nm, input int mode, input logic [23:0] solid,
                           input int sw_at, input logic [1:0] sw_sel);
    int n_de = 0, n_hs = 0, n_vs = 0, n_ls = 0, n_fs = 0, first_de = -1;
    int err_de = 0, err_pix = 0, err_rgb = 0;
    int h, v;
    logic act;
    logic [11:0] px, py;
    logic [23:0] er;
    for (int i = 0; i < FRAME; i++) begin
      h   = i % HT;
      v   = i / HT;
      act = (h >= HAB) && (h < HAE) && (v >= VAB) && (v < VAE);
      px  = act ? 12'(h - HAB) : 12'd0;
      py  = act ? 12'(v - VAB) : 12'd0;
      er  = act ? exp_rgb(mode, px, py, solid) : 24'h000000;
      if (vpg_de !== act) err_de++;
      if ((pix_x !== px) || (pix_y !== py)) err_pix++;
      if ({vpg_r, vpg_g, vpg_b} !== er) err_rgb++;
      if (vpg_de === 1'b1) begin
        n_de++;
        if (first_de < 0) first_de = i;
      end
      if (vpg_hs === 1'b0) n_hs++;
      if (vpg_vs === 1'b0) n_vs++;
      if (line_start === 1'b1) n_ls++;
      if (frame_start === 1'b1) n_fs++;
      if (i < 480) begin
        if (de2 === 1'b1) d2_de++;
        if (hs2 === 1'b1) d2_hs++;
        if (vs2 === 1'b1) d2_vs++;
        if ((de2 === 1'b1) && (int'(px2) > d2_maxx)) d2_maxx = int'(px2);
      end
      if (i == sw_at) pattern_sel = sw_sel;
      tick();
    end
    chk({nm, "_de_count"}, n_de, 2560);
    chk({nm, "_hs_low"}, n_hs, 376);
    chk({nm, "_vs_low"}, n_vs, 240);
    chk({nm, "_line_starts"}, n_ls, 47);
    chk({nm, "_frame_starts"}, n_fs, 1);
    chk({nm, "_first_de_pos"}, first_de, 412);
    chk({nm, "_de_shape_errs"}, err_de, 0);
    chk({nm, "_pix_errs"}, err_pix, 0);
    chk({nm, "_rgb_errs"}, err_rgb, 0);
  endtask

  initial begin
    int n_hs, n_ls, n_fs, err_hold;
    logic [52:0] prev;

    // Asynchronous reset, checked before any clock edge.
    #2 reset_n = 1'b0;
    #1;
    chk("rst_de", vpg_de, 1'b0);
    chk("rst_hs", vpg_hs, 1'b1);
    chk("rst_vs", vpg_vs, 1'b1);
    chk("rst_rgb", {vpg_r, vpg_g, vpg_b}, 24'h000000);
    chk("rst_pix", {pix_x, pix_y}, 24'h000000);
    chk("rst_strobes", {frame_start, line_start}, 2'b00);
    chk("rst_pos_hs", hs2, 1'b0);
    chk("rst_pos_vs", vs2, 1'b0);
    tick();
    tick();
    @(negedge clk);
    reset_n = 1'b1;
    en      = 1'b1;
    tick();
    chk("lat1_fs", frame_start, 1'b0);
    chk("lat1_hs", vpg_hs, 1'b1);
    tick();
    chk("lat2_fs", frame_start, 1'b1);
    chk("lat2_ls", line_start, 1'b1);
    chk("lat2_hs", vpg_hs, 1'b0);
    chk("lat2_vs", vpg_vs, 1'b0);

    // Frame 0 bars (switch to checker mid-frame), frame 1 checker, frame 2 grey ramp.
    run_frame("f0_bars", 0, 24'h000000, 2000, 2'd2);
    chk("pos_de_count", d2_de, 240);
    chk("pos_hs_high", d2_hs, 40);
    chk("pos_vs_high", d2_vs, 96);
    chk("pos_max_pix_x", d2_maxx, 39);
    run_frame("f1_check", 2, 24'h000000, 2000, 2'd1);
    run_frame("f2_ramp", 1, 24'h000000, -1, 2'd0);

    // en toggling 0101...: each output index shows for two clocks, nothing moves on en-low edges.
    n_hs = 0; n_ls = 0; n_fs = 0; err_hold = 0;
    for (int k = 1; k <= 320; k++) begin
      en   = ((k % 2) == 0);
      prev = snap();
      tick();
      if (!en && (snap() !== prev)) err_hold++;
      if (vpg_hs === 1'b0) n_hs++;
      if (line_start === 1'b1) n_ls++;
      if (frame_start === 1'b1) n_fs++;
    end
    chk("half_rate_hold_errs", err_hold, 0);
    chk("half_rate_hs_low", n_hs, 32);
    chk("half_rate_line_starts", n_ls, 4);
    chk("half_rate_frame_start", n_fs, 1);

    // Move to pixel (48,0) of frame 3, still grey ramp.
    en = 1'b1;
    for (int k = 0; k < 300; k++) tick();
    chk("pre_rst_de", vpg_de, 1'b1);
    chk("pre_rst_pix_x", pix_x, 12'd48);
    chk("pre_rst_rgb", {vpg_r, vpg_g, vpg_b}, 24'h303030);

    // Reset pulsed mid-line with solid 123456 selected.
    pattern_sel = 2'd3;
    solid_rgb   = 24'h123456;
    #2 reset_n  = 1'b0;
    en          = 1'b0;
    #1;
    chk("mid_rst_de", vpg_de, 1'b0);
    chk("mid_rst_hs", vpg_hs, 1'b1);
    chk("mid_rst_vs", vpg_vs, 1'b1);
    chk("mid_rst_rgb", {vpg_r, vpg_g, vpg_b}, 24'h000000);
    chk("mid_rst_pix", {pix_x, pix_y}, 24'h000000);
    chk("mid_rst_strobes", {frame_start, line_start}, 2'b00);
    tick();
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    tick();
    tick();
    chk("idle_after_rst_fs", frame_start, 1'b0);
    chk("idle_after_rst_hs", vpg_hs, 1'b1);
    en = 1'b1;
    tick();
    chk("rel_lat1_fs", frame_start, 1'b0);
    tick();
    chk("rel_lat2_fs", frame_start, 1'b1);
    run_frame("f_solid", 3, 24'h123456, -1, 2'd3);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
